spmv_csr_fetch: RTL and testbench



---
 rtl/spmv_csr_fetch.sv | 164 ++++++++++++++++
 tb/tb_spmv_csr_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_csr_fetch.sv
// CSR non-zero fetch sequencer: walks k = 0..nnz-1, reads value/col_idx, then vector[col],
// and presents (vector, value, 1-based ordinal) to the accumulator with fixed 3-cycle latency.
module spmv_csr_fetch #(
    parameter int NNZ_W        = 8,
    parameter int VEC_AW       = 4,
    parameter int ISSUE_GAP    = 0,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NNZ_W-1:0]  i_nnz,
    output logic              o_rd_en,
    output logic [NNZ_W-1:0]  o_nz_addr,
    input  logic [15:0]       i_val_data,
    input  logic [NNZ_W-1:0]  i_col_data,
    output logic              o_vec_rd_en,
    output logic [VEC_AW-1:0] o_vec_addr,
    input  logic [15:0]       i_vec_data,
    output logic [15:0]       o_data_A,
    output logic [15:0]       o_data_B,
    output logic [NNZ_W-1:0]  o_count,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] GAP_LAST   = 16'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES);

    state_t             state;
    logic [NNZ_W-1:0]   nnz;
    logic [NNZ_W-1:0]   idx;
    logic [15:0]        gap_cnt;
    logic [15:0]        drain_cnt;

    logic               s1_valid;
    logic [NNZ_W-1:0]   s1_idx;
    logic               s2_valid;
    logic [NNZ_W-1:0]   s2_idx;
    logic [15:0]        s2_val;

    logic               pipe_empty;
    logic               unused_col_hi;

    // o_valid is excluded: the last pair is already out when the drain count starts.
    assign pipe_empty = !s1_valid && !s2_valid;

    // Issue FSM. o_rd_en / o_nz_addr are registered alongside the state so they
    // change on the same edge the state enters or leaves ISSUE.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            nnz       <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            drain_cnt <= '0;
            o_rd_en   <= 1'b0;
            o_nz_addr <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        nnz       <= i_nnz;
                        idx       <= '0;
                        o_busy    <= 1'b1;
                        drain_cnt <= '0;
                        if (i_nnz == '0) begin
                            state <= DRAIN;
                        end else begin
                            state     <= ISSUE;
                            o_rd_en   <= 1'b1;
                            o_nz_addr <= '0;
                        end
                    end
                end
                ISSUE: begin
                    idx <= idx + 1'b1;
                    if (idx == nnz - 1'b1) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        o_rd_en   <= 1'b0;
                        o_nz_addr <= '0;
                    end else if (ISSUE_GAP > 0) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        o_rd_en   <= 1'b0;
                        o_nz_addr <= '0;
                    end else begin
                        o_nz_addr <= idx + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= ISSUE;
                        o_rd_en   <= 1'b1;
                        o_nz_addr <= idx;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Vector read is launched straight from the col_idx memory output.
    assign o_vec_rd_en   = s1_valid;
    assign o_vec_addr    = s1_valid ? i_col_data[VEC_AW-1:0] : '0;
    assign unused_col_hi = ^i_col_data[NNZ_W-1:VEC_AW];

    // Operand pipeline. Payloads are zeroed whenever their valid is low so an
    // accidental accumulate downstream adds +0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_val   <= '0;
            o_valid  <= 1'b0;
            o_data_A <= '0;
            o_data_B <= '0;
            o_count  <= '0;
        end else begin
            s1_valid <= o_rd_en;
            s1_idx   <= o_nz_addr;
            s2_valid <= s1_valid;
            s2_idx   <= s1_valid ? s1_idx : '0;
            s2_val   <= s1_valid ? i_val_data : '0;
            o_valid  <= s2_valid;
            o_data_A <= s2_valid ? i_vec_data : '0;
            o_data_B <= s2_valid ? s2_val : '0;
            o_count  <= s2_valid ? s2_idx + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Directed bench for spmv_csr_fetch: two instances (ISSUE_GAP=0 and ISSUE_GAP=2)
// over behavioural synchronous memories, compared cycle by cycle against hand-derived vectors.
module tb_spmv_csr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] val_mem [0:255];
    logic [7:0]  col_mem [0:255];
    logic [15:0] vec_mem [0:15];

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  nnz0 = '0, nnz1 = '0;
    logic        rd_en0, rd_en1, vec_rd_en0, vec_rd_en1;
    logic [7:0]  nz_addr0, nz_addr1;
    logic [3:0]  vec_addr0, vec_addr1;
    logic [15:0] val_rd0 = '0, val_rd1 = '0, vec_rd0 = '0, vec_rd1 = '0;
    logic [7:0]  col_rd0 = '0, col_rd1 = '0;
    logic [15:0] a0, a1, b0, b1;
    logic [7:0]  cnt0, cnt1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    int total = 0;
    int bad   = 0;

    spmv_csr_fetch #(.NNZ_W(8), .VEC_AW(4), .ISSUE_GAP(0), .DRAIN_CYCLES(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_nnz(nnz0),
        .o_rd_en(rd_en0), .o_nz_addr(nz_addr0), .i_val_data(val_rd0), .i_col_data(col_rd0),
        .o_vec_rd_en(vec_rd_en0), .o_vec_addr(vec_addr0), .i_vec_data(vec_rd0),
        .o_data_A(a0), .o_data_B(b0), .o_count(cnt0), .o_valid(valid0),
        .o_busy(busy0), .o_done(done0)
    );

    spmv_csr_fetch #(.NNZ_W(8), .VEC_AW(4), .ISSUE_GAP(2), .DRAIN_CYCLES(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_nnz(nnz1),
        .o_rd_en(rd_en1), .o_nz_addr(nz_addr1), .i_val_data(val_rd1), .i_col_data(col_rd1),
        .o_vec_rd_en(vec_rd_en1), .o_vec_addr(vec_addr1), .i_vec_data(vec_rd1),
        .o_data_A(a1), .o_data_B(b1), .o_count(cnt1), .o_valid(valid1),
        .o_busy(busy1), .o_done(done1)
    );

    always @(posedge clk) begin
        if (rd_en0) begin
            val_rd0 <= val_mem[nz_addr0];
            col_rd0 <= col_mem[nz_addr0];
        end
        if (vec_rd_en0) vec_rd0 <= vec_mem[vec_addr0];
        if (rd_en1) begin
            val_rd1 <= val_mem[nz_addr1];
            col_rd1 <= col_mem[nz_addr1];
        end
        if (vec_rd_en1) vec_rd1 <= vec_mem[vec_addr1];
    end

    function automatic logic [56:0] pack0();
        return {rd_en0, nz_addr0, vec_rd_en0, vec_addr0, valid0, a0, b0, cnt0, busy0, done0};
    endfunction

    function automatic logic [56:0] pack1();
        return {rd_en1, nz_addr1, vec_rd_en1, vec_addr1, valid1, a1, b1, cnt1, busy1, done1};
    endfunction

    function automatic logic [56:0] mk(input logic rd, input logic [7:0] addr, input logic vrd,
                                       input logic [3:0] vaddr, input logic v, input logic [15:0] a,
                                       input logic [15:0] b, input logic [7:0] cnt,
                                       input logic busy, input logic done);
        return {rd, addr, vrd, vaddr, v, a, b, cnt, busy, done};
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) begin
            val_mem[k] = '0;
            col_mem[k] = '0;
        end
        for (int k = 0; k < 16; k++) vec_mem[k] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (pack0() !== 57'd0) begin
            bad++;
            $display("FAIL reset_dut0 got=%h exp=0", pack0());
        end
        total++;
        if (pack1() !== 57'd0) begin
            bad++;
            $display("FAIL reset_dut1 got=%h exp=0", pack1());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [56:0] exp;
        logic [15:0] ea [0:2];
        logic [15:0] eb [0:2];
        logic [3:0]  ev [0:2];
        ea[0] = 16'h3800; ea[1] = 16'h4400; ea[2] = 16'hBC00;
        eb[0] = 16'h3C00; eb[1] = 16'h4000; eb[2] = 16'h4200;
        ev[0] = 4'd2;     ev[1] = 4'd0;     ev[2] = 4'd15;
        clear_mem();
        val_mem[0] = 16'h3C00; val_mem[1] = 16'h4000; val_mem[2] = 16'h4200;
        col_mem[0] = 8'd2;     col_mem[1] = 8'd0;     col_mem[2] = 8'd15;
        vec_mem[2] = 16'h3800; vec_mem[0] = 16'h4400; vec_mem[15] = 16'hBC00;
        nnz0 = 8'd3;
        start0 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            exp = mk((c >= 1 && c <= 3), (c >= 1 && c <= 3) ? 8'(c - 1) : 8'd0,
                     (c >= 2 && c <= 4), (c >= 2 && c <= 4) ? ev[c-2] : 4'd0,
                     (c >= 4 && c <= 6),
                     (c >= 4 && c <= 6) ? ea[c-4] : 16'd0,
                     (c >= 4 && c <= 6) ? eb[c-4] : 16'd0,
                     (c >= 4 && c <= 6) ? 8'(c - 3) : 8'd0,
                     (c <= 11), (c == 11));
            total++;
            if (pack0() !== exp) begin
                bad++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, pack0(), exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [56:0] exp;
        clear_mem();
        val_mem[0] = 16'h3C00; val_mem[1] = 16'h4000;
        col_mem[0] = 8'd2;     col_mem[1] = 8'd0;
        vec_mem[2] = 16'h3800; vec_mem[0] = 16'h4400;
        nnz1 = 8'd2;
        start1 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            exp = mk((c == 1 || c == 4), (c == 4) ? 8'd1 : 8'd0,
                     (c == 2 || c == 5), (c == 2) ? 4'd2 : 4'd0,
                     (c == 4 || c == 7),
                     (c == 4) ? 16'h3800 : (c == 7) ? 16'h4400 : 16'd0,
                     (c == 4) ? 16'h3C00 : (c == 7) ? 16'h4000 : 16'd0,
                     (c == 4) ? 8'd1 : (c == 7) ? 8'd2 : 8'd0,
                     (c <= 12), (c == 12));
            total++;
            if (pack1() !== exp) begin
                bad++;
                $display("FAIL gap c=%0d got=%h exp=%h", c, pack1(), exp);
            end
        end
    endtask

    task automatic test_nnz_zero();
        logic [56:0] exp;
        nnz0 = 8'd0;
        start0 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            exp = mk(1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 16'd0, 16'd0, 8'd0, (c <= 6), (c == 6));
            total++;
            if (pack0() !== exp) begin
                bad++;
                $display("FAIL nnz0 c=%0d got=%h exp=%h", c, pack0(), exp);
            end
        end
    endtask

    task automatic test_restart_ignored();
        logic [56:0] exp;
        int nvalid = 0;
        int ndone  = 0;
        clear_mem();
        for (int k = 0; k < 5; k++) begin
            val_mem[k] = 16'h1000 + 16'(k);
            col_mem[k] = 8'(k);
            vec_mem[k] = 16'h2000 + 16'(k);
        end
        nnz0 = 8'd5;
        start0 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (valid0) nvalid++;
            if (done0) ndone++;
            exp = mk((c <= 5), (c <= 5) ? 8'(c - 1) : 8'd0,
                     (c >= 2 && c <= 6), (c >= 2 && c <= 6) ? 4'(c - 2) : 4'd0,
                     (c >= 4 && c <= 8),
                     (c >= 4 && c <= 8) ? 16'h2000 + 16'(c - 4) : 16'd0,
                     (c >= 4 && c <= 8) ? 16'h1000 + 16'(c - 4) : 16'd0,
                     (c >= 4 && c <= 8) ? 8'(c - 3) : 8'd0,
                     (c <= 13), (c == 13));
            total++;
            if (pack0() !== exp) begin
                bad++;
                $display("FAIL restart c=%0d got=%h exp=%h", c, pack0(), exp);
            end
            start0 = (c == 2);
        end
        total++;
        if (nvalid != 5 || ndone != 1) begin
            bad++;
            $display("FAIL restart_counts got valids=%0d dones=%0d exp valids=5 dones=1", nvalid, ndone);
        end
    endtask

    task automatic test_abort();
        logic [56:0] exp;
        nnz0 = 8'd4;
        start0 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 4; c <= 20; c++) begin
            total++;
            if (pack0() !== 57'd0) begin
                bad++;
                $display("FAIL abort c=%0d got=%h exp=0", c, pack0());
            end
            @(negedge clk);
        end
        start0 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        rst = 1'b0;
        total++;
        if (pack0() !== 57'd0) begin
            bad++;
            $display("FAIL start_with_rst got=%h exp=0", pack0());
        end
        nnz0 = 8'd2;
        start0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            exp = mk((c <= 2), (c <= 2) ? 8'(c - 1) : 8'd0,
                     (c == 2 || c == 3), (c == 3) ? 4'd1 : 4'd0,
                     (c == 4 || c == 5),
                     (c == 4 || c == 5) ? 16'h2000 + 16'(c - 4) : 16'd0,
                     (c == 4 || c == 5) ? 16'h1000 + 16'(c - 4) : 16'd0,
                     (c == 4 || c == 5) ? 8'(c - 3) : 8'd0,
                     (c <= 10), (c == 10));
            total++;
            if (pack0() !== exp) begin
                bad++;
                $display("FAIL after_abort c=%0d got=%h exp=%h", c, pack0(), exp);
            end
        end
    endtask

    task automatic test_trunc_max();
        int nvalid   = 0;
        int ndone    = 0;
        int done_cyc = -1;
        logic [7:0] last_cnt = '0;
        clear_mem();
        for (int k = 0; k < 255; k++) begin
            val_mem[k] = 16'(k);
            col_mem[k] = 8'h1F;
        end
        vec_mem[15] = 16'h5555;
        nnz0 = 8'd255;
        start0 = 1'b1;
        for (int c = 1; c <= 270; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (vec_rd_en0) begin
                total++;
                if (vec_addr0 !== 4'hF) begin
                    bad++;
                    $display("FAIL trunc_addr c=%0d got=%h exp=f", c, vec_addr0);
                end
            end
            if (valid0) begin
                total++;
                if ({a0, b0, cnt0} !== {16'h5555, 16'(nvalid), 8'(nvalid + 1)}) begin
                    bad++;
                    $display("FAIL max_pair c=%0d got=%h/%h/%0d exp=5555/%h/%0d",
                             c, a0, b0, cnt0, 16'(nvalid), nvalid + 1);
                end
                nvalid++;
                last_cnt = cnt0;
            end
            if (done0) begin
                ndone++;
                done_cyc = c;
            end
        end
        total++;
        if (nvalid != 255 || last_cnt !== 8'd255) begin
            bad++;
            $display("FAIL max_count got valids=%0d last=%0d exp valids=255 last=255", nvalid, last_cnt);
        end
        total++;
        if (ndone != 1 || done_cyc != 263) begin
            bad++;
            $display("FAIL max_done got dones=%0d at=%0d exp dones=1 at=263", ndone, done_cyc);
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_gap();
        test_nnz_zero();
        test_restart_ignored();
        test_abort();
        repeat (3) @(negedge clk);
        test_trunc_max();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
